// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns one MEM-stage load/store into a memory
// command, waits for grant and read data, and returns a raw doubleword response.
module dmem_access_ctrl #(
    parameter int DMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshakes: a request transfers on a cycle with req_valid && req_ready;
    // a command transfers on a cycle with mem_req && mem_gnt, with every mem_*
    // output held stable until then; read data transfers on mem_rvalid and a
    // response is a single-cycle rsp_valid pulse with no back-pressure.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_re,
    input  logic               req_we,
    input  logic [2:0]         req_func3,
    input  logic [63:0]        req_addr,
    input  logic [63:0]        req_wdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [63:0]        mem_wdata,
    output logic [7:0]         mem_wstrb,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [63:0]        mem_rdata,
    output logic               rsp_valid,
    output logic               rsp_re,
    output logic [2:0]         rsp_func3,
    output logic [2:0]         rsp_addr_local,
    output logic [63:0]        rsp_data,
    output logic               rsp_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_we;
    logic [DMEM_AW-1:0]   r_mem_addr;
    logic [63:0]          r_wdata;
    logic [7:0]           r_wstrb;
    logic [2:0]           r_func3;
    logic [2:0]           r_addr_local;
    logic                 r_err;
    logic                 r_rsp_re;
    logic [63:0]          r_rsp_data;

    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_misaligned;
    logic                 w_err;
    logic [7:0]           w_strb;
    logic [63:0]          w_wdata;
    logic                 w_unused;

    assign w_unused  = ^req_addr[63:DMEM_AW+3];

    assign req_ready = (r_state == IDLE) && rst_n;
    assign w_accept  = req_valid && req_ready;

    assign w_illegal = (req_re == req_we)
                     || (req_re && (req_func3 == 3'b111))
                     || (req_we && (req_func3 > 3'b011));
    assign w_err     = w_illegal || w_misaligned;

    // func3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        w_misaligned = 1'b0;
        w_strb       = 8'h00;
        w_wdata      = req_wdata;
        case (req_func3[1:0])
            2'b00: begin
                w_strb  = 8'h01 << req_addr[2:0];
                w_wdata = {8{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = req_addr[0];
                w_strb       = 8'h03 << req_addr[2:0];
                w_wdata      = {4{req_wdata[15:0]}};
            end
            2'b10: begin
                w_misaligned = |req_addr[1:0];
                w_strb       = 8'h0F << req_addr[2:0];
                w_wdata      = {2{req_wdata[31:0]}};
            end
            default: begin
                w_misaligned = |req_addr[2:0];
                w_strb       = 8'hFF;
                w_wdata      = req_wdata;
            end
        endcase
        if (!req_we) begin
            w_strb = 8'h00;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_err ? RESP : CMD;
            CMD:     if (mem_gnt) w_next = r_we ? RESP : RWAIT;
            RWAIT:   if (mem_rvalid) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_func3      <= '0;
            r_addr_local <= '0;
            r_err        <= 1'b0;
            r_rsp_re     <= 1'b0;
            r_rsp_data   <= '0;
        end else if (w_accept) begin
            r_func3      <= req_func3;
            r_addr_local <= req_addr[2:0];
            r_err        <= w_err;
            r_rsp_re     <= 1'b0;
            r_rsp_data   <= '0;
            // Rejected requests never reach memory, so the command port keeps its last value.
            if (!w_err) begin
                r_we       <= req_we;
                r_mem_addr <= req_addr[DMEM_AW+2:3];
                r_wdata    <= w_wdata;
                r_wstrb    <= w_strb;
            end
        end else if ((r_state == RWAIT) && mem_rvalid) begin
            r_rsp_re   <= 1'b1;
            r_rsp_data <= mem_rdata;
        end
    end

    assign mem_req        = (r_state == CMD);
    assign mem_we         = r_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_wdata;
    assign mem_wstrb      = r_wstrb;

    assign rsp_valid      = (r_state == RESP);
    assign rsp_re         = r_rsp_re;
    assign rsp_func3      = r_func3;
    assign rsp_addr_local = r_addr_local;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_err;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: expected responses are queued when a
// request is issued and compared when rsp_valid pulses.
module tb_dmem_access_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_re, req_we;
  logic [2:0]    req_func3;
  logic [63:0]   req_addr, req_wdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic [7:0]    mem_wstrb;
  logic          rsp_valid, rsp_re, rsp_err;
  logic [2:0]    rsp_func3, rsp_addr_local;
  logic [63:0]   rsp_data;
  logic [1:0]    dbg_state;

  logic [71:0]   exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [63:0]   rd;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_access_ctrl #(.DMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_re(req_re), .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_re(rsp_re), .rsp_func3(rsp_func3),
    .rsp_addr_local(rsp_addr_local), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed no summary by 100000ns, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack_rsp(input logic err, input logic re, input logic [2:0] f3,
                                           input logic [2:0] al, input logic [63:0] d);
    return {err, re, f3, al, d};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Drives one request for the acceptance cycle; returns in the following cycle.
  task automatic send(input logic re, input logic we, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wdata, input logic [71:0] exp);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_re    = re;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back(exp);
    cyc();
    req_valid = 1'b0;
    req_re    = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic load_imm(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] data, input logic [AW-1:0] exp_maddr, input logic [2:0] exp_al);
    mem_gnt = 1'b1;
    send(1'b1, 1'b0, f3, addr, 64'h0, pack_rsp(1'b0, 1'b1, f3, exp_al, data));
    check({tag, "_cmd"}, {mem_req, mem_we, mem_wstrb, mem_addr}, {1'b1, 1'b0, 8'h00, exp_maddr});
    cyc();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    check({tag, "_rwait"}, {rsp_valid, mem_req}, 2'b00);
    cyc();
    mem_rvalid = 1'b0;
    check({tag, "_rsp_n3"}, rsp_valid, 1'b1);
    cyc();
    check({tag, "_after"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic store_imm(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [AW-1:0] exp_maddr,
                           input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
    mem_gnt = 1'b1;
    send(1'b0, 1'b1, f3, addr, wdata, pack_rsp(1'b0, 1'b0, f3, addr[2:0], 64'h0));
    check({tag, "_cmd"}, {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata},
          {1'b1, 1'b1, exp_maddr, exp_strb, exp_wdata});
    cyc();
    mem_gnt = 1'b0;
    check({tag, "_rsp_n2"}, {rsp_valid, mem_req}, 2'b10);
    cyc();
    check({tag, "_after"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic err_case(input string tag, input logic re, input logic we,
                          input logic [2:0] f3, input logic [63:0] addr);
    send(re, we, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF, pack_rsp(1'b1, 1'b0, f3, addr[2:0], 64'h0));
    check({tag, "_rsp_n1"}, {rsp_valid, mem_req, dbg_state}, {1'b1, 1'b0, 2'd3});
    cyc();
    check({tag, "_after"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected: observed rsp_valid=1 expected no response");
      end
      if (exp_q.size() > 0) begin
        check("rsp_fields", {rsp_err, rsp_re, rsp_func3, rsp_addr_local, rsp_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_re     = 1'b0;
    req_we     = 1'b0;
    req_func3  = 3'b000;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    #1 rst_n = 1'b0;
    cyc();
    cyc();
    check("rst_ctrl", {req_ready, mem_req, mem_we, mem_wstrb, rsp_valid, rsp_re, rsp_err,
                       rsp_func3, rsp_addr_local}, '0);
    check("rst_data", {mem_addr, mem_wdata, rsp_data}, '0);
    rst_n = 1'b1;
    cyc();
    check("rst_release_ready", req_ready, 1'b1);

    // Load, immediate grant and read data.
    load_imm("ld_0x10", 3'b011, 64'h10, 64'h1122334455667788, 12'd2, 3'd0);

    // Read data while idle must not produce a response.
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    cyc();
    mem_rvalid = 1'b0;
    cyc();
    check("idle_rvalid_ignored", {rsp_valid, req_ready}, 2'b01);

    // Halfword store with grant held off for three cycles.
    mem_gnt = 1'b0;
    send(1'b0, 1'b1, 3'b001, 64'h0A, 64'hBEEF, pack_rsp(1'b0, 1'b0, 3'b001, 3'd2, 64'h0));
    for (int i = 0; i < 3; i++) begin
      check("sh_cmd_held", {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, rsp_valid},
            {1'b1, 1'b1, 12'd1, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 1'b0});
      if (i < 2) cyc();
    end
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    check("sh_rsp", {rsp_valid, mem_req}, 2'b10);
    cyc();
    check("sh_after", {rsp_valid, req_ready}, 2'b01);

    // Stores of each size, including the top of the index range.
    store_imm("sb", 3'b000, 64'h13, 64'h1234_5678_9ABC_DEA5, 12'd2, 8'h08, 64'hA5A5_A5A5_A5A5_A5A5);
    store_imm("sw", 3'b010, 64'h24, 64'hFFFF_0000_CAFE_F00D, 12'd4, 8'hF0, 64'hCAFE_F00D_CAFE_F00D);
    store_imm("sd", 3'b011, 64'h0000_0001_0000_7FF8, 64'h0123_4567_89AB_CDEF, 12'hFFF, 8'hFF,
              64'h0123_4567_89AB_CDEF);

    // Rejected requests.
    err_case("lw_mis",   1'b1, 1'b0, 3'b010, 64'h06);
    err_case("re_we_11", 1'b1, 1'b1, 3'b000, 64'h00);
    err_case("re_we_00", 1'b0, 1'b0, 3'b000, 64'h08);
    err_case("ld_f3_7",  1'b1, 1'b0, 3'b111, 64'h00);
    err_case("st_f3_4",  1'b0, 1'b1, 3'b100, 64'h00);
    err_case("lh_mis",   1'b1, 1'b0, 3'b001, 64'h01);
    err_case("sd_mis",   1'b0, 1'b1, 3'b011, 64'h04);
    err_case("sw_mis",   1'b0, 1'b1, 3'b010, 64'h02);

    // lbu at byte 7, spurious rvalid in the grant cycle, real data four cycles later.
    rd = {$urandom, $urandom};
    mem_gnt = 1'b1;
    send(1'b1, 1'b0, 3'b100, 64'h0F, 64'h0, pack_rsp(1'b0, 1'b1, 3'b100, 3'd7, rd));
    check("lbu_cmd", {req_ready, mem_req, mem_wstrb, mem_addr}, {1'b0, 1'b1, 8'h00, 12'd1});
    mem_rvalid = 1'b1;
    mem_rdata  = ~rd;
    cyc();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lbu_wait", {req_ready, rsp_valid}, 2'b00);
      cyc();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    check("lbu_rvalid_cycle", {req_ready, rsp_valid}, 2'b00);
    cyc();
    mem_rvalid = 1'b0;
    check("lbu_rsp", {req_ready, rsp_valid}, 2'b01);
    cyc();
    check("lbu_after", {rsp_valid, req_ready}, 2'b01);

    // Reset while waiting for read data, then a late rvalid.
    rd = {$urandom, $urandom};
    mem_gnt = 1'b1;
    send(1'b1, 1'b0, 3'b011, 64'h40, 64'hA5A5_0000_1111_2222, pack_rsp(1'b0, 1'b1, 3'b011, 3'd0, rd));
    check("rst_ld_cmd", {mem_req, mem_addr}, {1'b1, 12'd8});
    cyc();
    mem_gnt = 1'b0;
    check("rst_ld_rwait", dbg_state, 2'd2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ctrl", {req_ready, mem_req, mem_we, mem_wstrb, rsp_valid, rsp_re, rsp_err,
                           rsp_func3, rsp_addr_local}, '0);
    check("mid_rst_data", {mem_addr, mem_wdata, rsp_data}, '0);
    cyc();
    rst_n = 1'b1;
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    check("post_rst_ready", req_ready, 1'b1);
    cyc();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_no_rsp", {rsp_valid, req_ready}, 2'b01);
      cyc();
    end
    load_imm("ld_after_rst", 3'b011, 64'h08, {$urandom, $urandom}, 12'd1, 3'd0);

    cyc();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
